round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/fight_pkg.sv | 55 +++++
 rtl/round_controller_hit_detector.sv | 36 +++
 rtl/round_controller.sv | 186 ++++++++++++++++++
 tb/tb_round_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared encodings and combat constants for the fighting-game round controller.
// Imported by the round controller and its per-attacker hit detector.
package fight_pkg;

  typedef enum logic [1:0] {
    GS_IDLE      = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_FIGHT     = 2'd2,
    GS_KO        = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  localparam logic [2:0]  ST_ATTACK    = 3'd6;
  localparam logic [10:0] RANGE_BASIC  = 11'd40;
  localparam logic [10:0] RANGE_DIR    = 11'd56;
  localparam logic [2:0]  DMG_BASIC    = 3'd1;
  localparam logic [2:0]  DMG_DIR      = 3'd2;
  localparam logic [3:0]  STUN_BASIC   = 4'd10;
  localparam logic [3:0]  STUN_DIR     = 4'd15;
  localparam logic [2:0]  START_HEALTH = 3'd5;
  localparam logic [10:0] SPRITE_W     = 11'd64;

  function automatic logic [2:0] sat_sub(
    input logic [2:0] a,
    input logic [2:0] b
  );
    return (a > b) ? (a - b) : 3'd0;
  endfunction

  // Overlapping sprites read as a negative gap; treat that as touching.
  function automatic logic [10:0] calc_gap(
    input logic [9:0] p1x,
    input logic [9:0] p2x
  );
    logic [10:0] g;
    g = {1'b0, p2x} - {1'b0, p1x} - SPRITE_W;
    return g[10] ? 11'd0 : g;
  endfunction

  function automatic logic [3:0] stun_next(
    input logic [3:0] cur,
    input logic       hit,
    input logic [3:0] len
  );
    if (hit) return len;
    return (cur != 4'd0) ? (cur - 4'd1) : 4'd0;
  endfunction

endpackage

// File: rtl/round_controller_hit_detector.sv
// One attacker's hit test: range check, stun gating and a
// one-hit-per-active-window latch.
module hit_detector
  import fight_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [2:0]  state_i,
  input  logic        dir_i,
  input  logic [10:0] gap_i,
  input  logic        opp_stun_i,
  output logic        hit_o,
  output logic [2:0]  dmg_o,
  output logic [3:0]  stun_len_o
);

  logic latch_q, latch_d;
  logic active, in_range;

  assign active   = en_i && (state_i == ST_ATTACK);
  assign in_range = gap_i <= (dir_i ? RANGE_DIR : RANGE_BASIC);

  assign hit_o      = active && in_range && !opp_stun_i && !latch_q;
  assign dmg_o      = dir_i ? DMG_DIR : DMG_BASIC;
  assign stun_len_o = dir_i ? STUN_DIR : STUN_BASIC;

  // Latch stays set for the rest of the active window once it lands.
  assign latch_d = active && (latch_q || hit_o);

  always_ff @(posedge clk) begin
    if (reset) latch_q <= 1'b0;
    else       latch_q <= latch_d;
  end

endmodule

// File: rtl/round_controller.sv
// Round sequencing for a two-player fighter: countdown, timed fight,
// hit/damage/stun resolution and KO hold with winner decision.
module round_controller
  import fight_pkg::*;
#(
  parameter int ROUND_SECONDS    = 60,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int KO_HOLD_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic [2:0] p1_state,
  input  logic [2:0] p2_state,
  input  logic       p1_dir,
  input  logic       p2_dir,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  output logic       fighters_reset,
  output logic [1:0] game_state,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic [6:0] seconds_left,
  output logic [1:0] winner
);

  localparam int CM1 = (COUNTDOWN_FRAMES > KO_HOLD_FRAMES)
                     ? COUNTDOWN_FRAMES : KO_HOLD_FRAMES;
  localparam int CMX = (CM1 > FRAMES_PER_SEC) ? CM1 : FRAMES_PER_SEC;
  localparam int CW  = $clog2(CMX + 1);

  localparam logic [CW-1:0] CD_LAST = CW'(COUNTDOWN_FRAMES - 1);
  localparam logic [CW-1:0] KO_LAST = CW'(KO_HOLD_FRAMES - 1);
  localparam logic [CW-1:0] FR_LAST = CW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]    SEC_INIT = 7'(ROUND_SECONDS);

  game_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    sec_q, sec_d;
  logic [2:0]    h1_q, h1_d, h2_q, h2_d;
  logic [3:0]    st1_q, st1_d, st2_q, st2_d;
  winner_e       win_q, win_d;
  logic          fres_q, fres_d;

  logic        fight, end_round, hit_en;
  logic [10:0] gap;
  logic        hit1, hit2;
  logic [2:0]  dmg1, dmg2;
  logic [3:0]  len1, len2;

  assign gap       = calc_gap(p1_x, p2_x);
  assign fight     = (state_q == GS_FIGHT);
  assign end_round = fight &&
                     ((h1_q == 3'd0) || (h2_q == 3'd0) || (sec_q == 7'd0));
  assign hit_en    = fight && !end_round;

  hit_detector u_hit_p1 (
    .clk        (clk),
    .reset      (reset),
    .en_i       (hit_en),
    .state_i    (p1_state),
    .dir_i      (p1_dir),
    .gap_i      (gap),
    .opp_stun_i (st2_q != 4'd0),
    .hit_o      (hit1),
    .dmg_o      (dmg1),
    .stun_len_o (len1)
  );

  hit_detector u_hit_p2 (
    .clk        (clk),
    .reset      (reset),
    .en_i       (hit_en),
    .state_i    (p2_state),
    .dir_i      (p2_dir),
    .gap_i      (gap),
    .opp_stun_i (st1_q != 4'd0),
    .hit_o      (hit2),
    .dmg_o      (dmg2),
    .stun_len_o (len2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    st1_d   = st1_q;
    st2_d   = st2_q;
    win_d   = win_q;
    unique case (state_q)
      GS_IDLE: begin
        if (btn_start) begin
          state_d = GS_COUNTDOWN;
          cnt_d   = '0;
          sec_d   = SEC_INIT;
          h1_d    = START_HEALTH;
          h2_d    = START_HEALTH;
          st1_d   = 4'd0;
          st2_d   = 4'd0;
          win_d   = WIN_NONE;
        end
      end
      GS_COUNTDOWN: begin
        if (cnt_q == CD_LAST) begin
          state_d = GS_FIGHT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GS_FIGHT: begin
        if (end_round) begin
          state_d = GS_KO;
          cnt_d   = '0;
          st1_d   = 4'd0;
          st2_d   = 4'd0;
          unique case (1'b1)
            h1_q > h2_q:  win_d = WIN_P1;
            h2_q > h1_q:  win_d = WIN_P2;
            h1_q == h2_q: win_d = WIN_DRAW;
          endcase
        end else begin
          if (cnt_q == FR_LAST) begin
            cnt_d = '0;
            sec_d = (sec_q != 7'd0) ? (sec_q - 7'd1) : 7'd0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          // Trades resolve naturally: each side's hit only touches the other.
          h1_d  = sat_sub(h1_q, hit2 ? dmg2 : 3'd0);
          h2_d  = sat_sub(h2_q, hit1 ? dmg1 : 3'd0);
          st1_d = stun_next(st1_q, hit2, len2);
          st2_d = stun_next(st2_q, hit1, len1);
        end
      end
      GS_KO: begin
        if (cnt_q == KO_LAST) begin
          state_d = GS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    fres_d = (state_d != GS_FIGHT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GS_IDLE;
      cnt_q   <= '0;
      sec_q   <= SEC_INIT;
      h1_q    <= START_HEALTH;
      h2_q    <= START_HEALTH;
      st1_q   <= 4'd0;
      st2_q   <= 4'd0;
      win_q   <= WIN_NONE;
      fres_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      win_q   <= win_d;
      fres_q  <= fres_d;
    end
  end

  assign fighters_reset = fres_q;
  assign game_state     = state_q;
  assign p1_health      = h1_q;
  assign p2_health      = h2_q;
  assign p1_stun        = (st1_q != 4'd0);
  assign p2_stun        = (st2_q != 4'd0);
  assign seconds_left   = sec_q;
  assign winner         = win_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed round scenarios plus random play,
// all checked every cycle against an event-level model of the round rules.
module tb_round_controller;

  localparam int RS = 60;
  localparam int FPS = 60;
  localparam int CDF = 180;
  localparam int KHF = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [2:0] ps [2];
  logic       pd [2];
  logic [9:0] px [2];

  logic       fres;
  logic [1:0] gs;
  logic [2:0] h1, h2;
  logic       s1, s2;
  logic [6:0] secs;
  logic [1:0] win;

  int checks = 0;
  int failures = 0;

  round_controller #(
    .ROUND_SECONDS   (RS),
    .FRAMES_PER_SEC  (FPS),
    .COUNTDOWN_FRAMES(CDF),
    .KO_HOLD_FRAMES  (KHF)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .btn_start     (btn),
    .p1_state      (ps[0]),
    .p2_state      (ps[1]),
    .p1_dir        (pd[0]),
    .p2_dir        (pd[1]),
    .p1_x          (px[0]),
    .p2_x          (px[1]),
    .fighters_reset(fres),
    .game_state    (gs),
    .p1_health     (h1),
    .p2_health     (h2),
    .p1_stun       (s1),
    .p2_stun       (s2),
    .seconds_left  (secs),
    .winner        (win)
  );

  always #5 clk = ~clk;

  // Model: cycle index, phase entry time, health, stun expiry times.
  int cyc = 0;
  bit m_valid = 0;
  int ms = 0;
  int ent = 0;
  int mh [2];
  int sfrz = RS;
  int mwin = 0;
  int se [2];
  bit lat [2];

  function automatic int msecs();
    int s;
    if (ms != 2) return sfrz;
    s = RS - (cyc - ent) / FPS;
    return (s < 0) ? 0 : s;
  endfunction

  function automatic int mgap();
    int gi;
    logic signed [10:0] g11;
    gi = int'(px[1]) - int'(px[0]) - 64;
    g11 = 11'(gi);
    return (g11 < 0) ? 0 : int'(g11);
  endfunction

  always @(posedge clk) begin : model
    int nc;
    bit hit [2];
    bit evald;
    nc = cyc + 1;
    evald = 0;
    if (rst) begin
      ms = 0; ent = nc; mh[0] = 5; mh[1] = 5; sfrz = RS; mwin = 0;
      se[0] = 0; se[1] = 0; m_valid = 1;
    end else begin
      case (ms)
        0: if (btn) begin
          ms = 1; ent = nc; mh[0] = 5; mh[1] = 5; sfrz = RS; mwin = 0;
          se[0] = 0; se[1] = 0;
        end
        1: if (nc - ent == CDF) begin ms = 2; ent = nc; end
        2: begin
          if (mh[0] == 0 || mh[1] == 0 || msecs() == 0) begin
            sfrz = msecs();
            mwin = (mh[0] > mh[1]) ? 1 : (mh[1] > mh[0]) ? 2 : 3;
            ms = 3; ent = nc; se[0] = 0; se[1] = 0;
          end else begin
            evald = 1;
            for (int a = 0; a < 2; a++)
              hit[a] = ps[a] == 3'd6 && !lat[a] && !(cyc < se[1-a]) &&
                       mgap() <= (pd[a] ? 56 : 40);
            for (int a = 0; a < 2; a++) begin
              lat[a] = (ps[a] == 3'd6) && (lat[a] || hit[a]);
              if (hit[a]) begin
                mh[1-a] = mh[1-a] - (pd[a] ? 2 : 1);
                if (mh[1-a] < 0) mh[1-a] = 0;
                se[1-a] = nc + (pd[a] ? 15 : 10);
              end
            end
          end
        end
        3: if (nc - ent == KHF) begin ms = 0; ent = nc; end
        default: ;
      endcase
    end
    if (!evald) begin lat[0] = 0; lat[1] = 0; end
    cyc = nc;
  end

  always @(negedge clk) begin : compare
    int e_s;
    bit bad;
    if (m_valid) begin
      e_s = msecs();
      checks = checks + 1;
      bad = (int'(gs) != ms) || (fres != (ms != 2)) ||
            (int'(h1) != mh[0]) || (int'(h2) != mh[1]) ||
            (s1 != (cyc < se[0])) || (s2 != (cyc < se[1])) ||
            (int'(secs) != e_s) || (int'(win) != mwin);
      if (bad) begin
        failures = failures + 1;
        $display("FAIL outputs cyc=%0d act gs=%0d fr=%0b h=%0d/%0d st=%0b/%0b s=%0d w=%0d req gs=%0d fr=%0b h=%0d/%0d st=%0b/%0b s=%0d w=%0d",
                 cyc, gs, fres, h1, h2, s1, s2, secs, win,
                 ms, ms != 2, mh[0], mh[1], cyc < se[0], cyc < se[1], e_s, mwin);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    ps[0] = 3'd0; ps[1] = 3'd0; pd[0] = 1'b0; pd[1] = 1'b0;
  endtask

  initial begin
    idle_inputs();
    px[0] = 10'd100; px[1] = 10'd200;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    lit("reset_state", int'(gs), 0);
    lit("reset_fres", int'(fres), 1);
    lit("reset_health", int'(h1) * 8 + int'(h2), 45);
    lit("reset_secs", int'(secs), 60);
    lit("reset_winner", int'(win), 0);

    btn = 1'b1; tick(1); btn = 1'b0;
    lit("countdown_entry", int'(gs), 1);
    tick(179);
    lit("countdown_hold", int'(gs) * 2 + int'(fres), 3);
    tick(1);
    lit("fight_entry", int'(gs) * 2 + int'(fres), 4);

    ps[0] = 3'd6; tick(1);
    lit("basic_hit_h2", int'(h2), 4);
    lit("basic_hit_stun", int'(s2), 1);
    tick(1); ps[0] = 3'd0;
    lit("basic_once", int'(h2), 4);
    tick(8);
    lit("stun_last", int'(s2), 1);
    tick(1);
    lit("stun_over", int'(s2), 0);

    px[1] = 10'd214;
    ps[0] = 3'd6; tick(3); ps[0] = 3'd0; tick(1);
    lit("gap50_basic_miss", int'(h2), 4);
    ps[0] = 3'd6; pd[0] = 1'b1; tick(1);
    lit("gap50_dir_hit", int'(h2), 2);
    idle_inputs();
    tick(14);
    lit("dir_stun_last", int'(s2), 1);
    tick(1);
    lit("dir_stun_over", int'(s2), 0);

    px[1] = 10'd184;
    ps[0] = 3'd6; ps[1] = 3'd6; tick(1);
    lit("trade_health", int'(h1) * 8 + int'(h2), 33);
    lit("trade_stun", int'(s1) * 2 + int'(s2), 3);
    idle_inputs(); tick(15);

    ps[0] = 3'd6; pd[0] = 1'b1; tick(1);
    idle_inputs();
    lit("ko_saturate", int'(h2), 0);
    tick(1);
    lit("ko_state", int'(gs), 3);
    lit("ko_winner", int'(win), 1);
    tick(119);
    lit("ko_hold", int'(gs), 3);
    tick(1);
    lit("ko_to_idle", int'(gs), 0);

    btn = 1'b1; tick(1); btn = 1'b0;
    tick(180);
    lit("timeout_fight", int'(gs), 2);
    tick(3600);
    lit("timeout_secs", int'(secs), 0);
    tick(1);
    lit("timeout_ko", int'(gs), 3);
    lit("timeout_draw", int'(win), 3);
    tick(120);
    lit("timeout_idle", int'(gs), 0);

    btn = 1'b1; tick(1); btn = 1'b0;
    tick(180);
    ps[0] = 3'd6; rst = 1'b1; tick(1);
    rst = 1'b0; idle_inputs();
    lit("midreset_state", int'(gs) * 2 + int'(fres), 1);
    lit("midreset_nohit", int'(h2) * 2 + int'(s2), 10);

    for (int i = 0; i < 30000; i++) begin
      rst = ($urandom % 3000) == 0;
      btn = ($urandom % 6) == 0;
      for (int a = 0; a < 2; a++) begin
        if (($urandom % 4) == 0)
          ps[a] = (($urandom % 2) == 0) ? 3'd6 : 3'($urandom % 8);
        if (($urandom % 4) == 0) pd[a] = 1'($urandom % 2);
      end
      if (($urandom % 16) == 0) begin
        px[0] = 10'($urandom_range(0, 400));
        if (($urandom % 5) == 0) px[1] = 10'($urandom % 1024);
        else px[1] = px[0] + 10'($urandom_range(20, 140));
      end
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
